half_duplex_pin_ctrl: RTL and testbench

HALF_DUPLEX_PIN_CTRL -- requirements
Module: half_duplex_pin_ctrl

---
 rtl/half_duplex_pin_ctrl_pkg.sv | 18 +
 rtl/half_duplex_pin_sync.sv | 26 ++
 rtl/half_duplex_pin_ctrl.sv | 157 +++++++++++++++
 tb/tb_half_duplex_pin_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/half_duplex_pin_ctrl_pkg.sv
// Shared types and defaults for the half-duplex single-pin controller.
// Contents:
//   state_t               controller state encoding
//   CLKS_PER_BIT_DEFAULT  default clock cycles per serial bit
//   TURN_CYCLES_DEFAULT   default bus-release cycles between drive and sample
package half_duplex_pin_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_TURN   = 2'd2,
    ST_SAMPLE = 2'd3
  } state_t;

  localparam int CLKS_PER_BIT_DEFAULT = 4;
  localparam int TURN_CYCLES_DEFAULT  = 2;

endpackage

// File: rtl/half_duplex_pin_sync.sv
// Two-flop synchronizer for the asynchronous pad input.
// Ports:
//   clk    in  sole clock, rising edge
//   rst_n  in  asynchronous active-low reset, clears both flops to 0
//   d      in  asynchronous input
//   q      out synchronized output (two clk cycles of latency)
module pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/half_duplex_pin_ctrl.sv
// Half-duplex single-pin controller: drives a byte MSB first on a shared pin,
// releases the bus for a turnaround gap, then optionally samples a response
// byte MSB first from the same pin.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   tx_data[7:0]           byte to drive, MSB first
//   tx_expect              sample a response byte after the drive phase
//   tx_valid / tx_ready    request handshake; tx_ready high only in IDLE
//   pin_out, pin_oe        registered data / output enable to the IO cell
//   pin_in                 asynchronous pad input
//   rx_data[7:0]           last received byte
//   rx_valid               one-cycle pulse when rx_data updates
//   busy                   high in every state except IDLE
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | bus released, waiting for a request
// ST_DRIVE  | pin_oe=1, shifting 8 bits out, CLKS_PER_BIT cycles each
// ST_TURN   | bus released for TURN_CYCLES cycles before sampling/idle
// ST_SAMPLE | bus released, sampling 8 bits mid-period from pin_in
module half_duplex_pin_ctrl
  import half_duplex_pin_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int TURN_CYCLES  = TURN_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_expect,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       pin_out,
  output logic       pin_oe,
  input  logic       pin_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] turn_cnt;
  logic [7:0]    shreg;
  logic          expect_q;
  logic          pin_s;
  logic [7:0]    rx_shift_nxt;

  pin_sync u_pin_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin_in),
    .q     (pin_s)
  );

  // The mid-period sample and the final-cycle load can coincide when
  // CLKS_PER_BIT=2, so the load takes the already-shifted value.
  always_comb begin
    rx_shift_nxt = shreg;
    if (clk_cnt == CNT_MID) rx_shift_nxt = {shreg[6:0], pin_s};
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      turn_cnt <= '0;
      shreg    <= '0;
      expect_q <= 1'b0;
      tx_ready <= 1'b0;
      pin_out  <= 1'b0;
      pin_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            state    <= ST_DRIVE;
            tx_ready <= 1'b0;
            shreg    <= tx_data;
            expect_q <= tx_expect;
            pin_oe   <= 1'b1;
            pin_out  <= tx_data[7];
            clk_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end

        ST_DRIVE: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state    <= ST_TURN;
              pin_oe   <= 1'b0;
              pin_out  <= 1'b0;
              turn_cnt <= TURN_LOAD;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              pin_out <= shreg[6];
              shreg   <= {shreg[6:0], 1'b0};
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        ST_TURN: begin
          if (turn_cnt == '0) begin
            if (expect_q) begin
              state   <= ST_SAMPLE;
              clk_cnt <= '0;
              bit_cnt <= '0;
            end else begin
              state    <= ST_IDLE;
              tx_ready <= 1'b1;
            end
          end else begin
            turn_cnt <= turn_cnt - TW'(1);
          end
        end

        ST_SAMPLE: begin
          shreg <= rx_shift_nxt;
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              rx_data  <= rx_shift_nxt;
              rx_valid <= 1'b1;
              state    <= ST_IDLE;
              tx_ready <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_half_duplex_pin_ctrl.sv
// Directed bench for half_duplex_pin_ctrl with CLKS_PER_BIT=4, TURN_CYCLES=2.
// Cycle k is the k-th cycle after the accepting clock edge; outputs are
// sampled on the falling edge inside that cycle.
module tb_half_duplex_pin_ctrl;
  import half_duplex_pin_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_expect;
  logic       tx_valid;
  logic       tx_ready;
  logic       pin_out;
  logic       pin_oe;
  logic       pin_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int rx_pulses = 0;

  half_duplex_pin_ctrl #(
    .CLKS_PER_BIT (4),
    .TURN_CYCLES  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_expect (tx_expect),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .pin_out   (pin_out),
    .pin_oe    (pin_oe),
    .pin_in    (pin_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_pulses++;
  end

  // The pin may only be driven while the controller is in DRIVE.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (pin_oe !== 1'b0 && dut.state !== ST_DRIVE) begin
        errors++;
        $display("FAIL oe_outside_drive: pin_oe=%b state=%0d, required pin_oe=0", pin_oe, dut.state);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pin_oe !== 1'b0) begin errors++; $display("FAIL reset_pin_oe: got %b want 0", pin_oe); end
    checks++; if (pin_out !== 1'b0) begin errors++; $display("FAIL reset_pin_out: got %b want 0", pin_out); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL release_tx_ready_pre_edge: got %b want 0", tx_ready); end
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL release_tx_ready: got %b want 1", tx_ready); end
  endtask

  // Entered and left on a falling edge with the controller idle.
  task automatic test_drive(input logic [7:0] data, input string name);
    int start_pulses;
    logic exp_bit;
    start_pulses = rx_pulses;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_at_start: got %b want 1", name, tx_ready); end
    tx_data = data; tx_expect = 1'b0; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k <= 32) begin
        exp_bit = data[7 - (k - 1) / 4];
        checks++; if (pin_oe !== 1'b1) begin errors++; $display("FAIL %s_drive_oe k=%0d: got %b want 1", name, k, pin_oe); end
        checks++; if (pin_out !== exp_bit) begin errors++; $display("FAIL %s_drive_bit k=%0d: got %b want %b", name, k, pin_out, exp_bit); end
        checks++; if (busy !== 1'b1 || tx_ready !== 1'b0) begin errors++; $display("FAIL %s_drive_busy k=%0d: busy=%b ready=%b want 1/0", name, k, busy, tx_ready); end
      end else if (k <= 34) begin
        checks++; if (pin_oe !== 1'b0 || pin_out !== 1'b0) begin errors++; $display("FAIL %s_turn_pins k=%0d: oe=%b out=%b want 0/0", name, k, pin_oe, pin_out); end
        checks++; if (tx_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL %s_turn_ready k=%0d: ready=%b busy=%b want 0/1", name, k, tx_ready, busy); end
      end else begin
        checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s_idle_ready: ready=%b busy=%b want 1/0", name, tx_ready, busy); end
        checks++; if (pin_oe !== 1'b0) begin errors++; $display("FAIL %s_idle_oe: got %b want 0", name, pin_oe); end
      end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL %s_no_rx_valid k=%0d: got %b want 0", name, k, rx_valid); end
    end
    checks++; if (rx_pulses != start_pulses) begin errors++; $display("FAIL %s_rx_pulse_count: got %0d want %0d", name, rx_pulses, start_pulses); end
  endtask

  task automatic test_sample();
    logic [7:0] resp;
    logic [7:0] cmd;
    int start_pulses;
    resp = 8'hC3;
    cmd  = 8'h3C;
    start_pulses = rx_pulses;
    tx_data = cmd; tx_expect = 1'b1; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk);
      // Each response bit is presented two cycles ahead of its SAMPLE bit
      // period to absorb the synchronizer latency.
      if (k >= 33 && k <= 61 && ((k - 33) % 4) == 0) pin_in = resp[7 - (k - 33) / 4];
      if (k <= 32) begin
        checks++; if (pin_oe !== 1'b1 || pin_out !== cmd[7 - (k - 1) / 4]) begin errors++; $display("FAIL sample_cmd_drive k=%0d: oe=%b out=%b want 1/%b", k, pin_oe, pin_out, cmd[7 - (k - 1) / 4]); end
      end else if (k <= 66) begin
        checks++; if (pin_oe !== 1'b0 || pin_out !== 1'b0) begin errors++; $display("FAIL sample_bus_released k=%0d: oe=%b out=%b want 0/0", k, pin_oe, pin_out); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL sample_early_rx_valid k=%0d: got %b want 0", k, rx_valid); end
      end else if (k == 67) begin
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL sample_rx_valid: got %b want 1", rx_valid); end
        checks++; if (rx_data !== resp) begin errors++; $display("FAIL sample_rx_data: got %h want %h", rx_data, resp); end
        checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL sample_idle: ready=%b busy=%b want 1/0", tx_ready, busy); end
      end else begin
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL sample_rx_valid_width: got %b want 0", rx_valid); end
        checks++; if (rx_data !== resp) begin errors++; $display("FAIL sample_rx_data_hold: got %h want %h", rx_data, resp); end
      end
    end
    pin_in = 1'b0;
    checks++; if (rx_pulses != start_pulses + 1) begin errors++; $display("FAIL sample_pulse_count: got %0d want %0d", rx_pulses - start_pulses, 1); end
  endtask

  task automatic test_pin_noise();
    int start_pulses;
    start_pulses = rx_pulses;
    tx_data = 8'h5A; tx_expect = 1'b0; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k <= 34) pin_in = ~pin_in;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL noise_rx_valid k=%0d: got %b want 0", k, rx_valid); end
    end
    pin_in = 1'b0;
    checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL noise_rx_data: got %h want c3", rx_data); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL noise_idle_ready: got %b want 1", tx_ready); end
    checks++; if (rx_pulses != start_pulses) begin errors++; $display("FAIL noise_pulse_count: got %0d want %0d", rx_pulses, start_pulses); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] first;
    logic [7:0] second;
    int ready_cycles;
    first  = 8'h01;
    second = 8'hFF;
    ready_cycles = 0;
    tx_data = first; tx_expect = 1'b0; tx_valid = 1'b1;
    @(posedge clk); #1 tx_data = second;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k <= 69 && tx_ready === 1'b1) ready_cycles++;
      if (k <= 32) begin
        checks++; if (pin_oe !== 1'b1 || pin_out !== first[7 - (k - 1) / 4]) begin errors++; $display("FAIL b2b_first k=%0d: oe=%b out=%b want 1/%b", k, pin_oe, pin_out, first[7 - (k - 1) / 4]); end
      end else if (k == 35) begin
        checks++; if (tx_ready !== 1'b1 || pin_oe !== 1'b0) begin errors++; $display("FAIL b2b_gap: ready=%b oe=%b want 1/0", tx_ready, pin_oe); end
      end else if (k >= 36 && k <= 67) begin
        if (k == 36) tx_valid = 1'b0;
        checks++; if (pin_oe !== 1'b1 || pin_out !== second[7 - (k - 36) / 4]) begin errors++; $display("FAIL b2b_second k=%0d: oe=%b out=%b want 1/%b", k, pin_oe, pin_out, second[7 - (k - 36) / 4]); end
      end else if (k == 70) begin
        checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end_idle: ready=%b busy=%b want 1/0", tx_ready, busy); end
      end
    end
    tx_valid = 1'b0;
    checks++; if (ready_cycles != 1) begin errors++; $display("FAIL b2b_ready_cycles: got %0d want 1", ready_cycles); end
  endtask

  task automatic test_reset_mid();
    int start_pulses;
    start_pulses = rx_pulses;
    tx_data = 8'hA5; tx_expect = 1'b1; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    checks++; if (pin_oe !== 1'b1) begin errors++; $display("FAIL rmid_oe_before: got %b want 1", pin_oe); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (pin_oe !== 1'b0 || pin_out !== 1'b0) begin errors++; $display("FAIL rmid_pins_async: oe=%b out=%b want 0/0", pin_oe, pin_out); end
    checks++; if (busy !== 1'b0 || tx_ready !== 1'b0) begin errors++; $display("FAIL rmid_busy_ready: busy=%b ready=%b want 0/0", busy, tx_ready); end
    checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_rx: data=%h valid=%b want 00/0", rx_data, rx_valid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      checks++; if (pin_oe !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_quiet k=%0d: oe=%b rx_valid=%b want 0/0", k, pin_oe, rx_valid); end
      if (k == 0) begin
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after_release: got %b want 1", tx_ready); end
      end
    end
    checks++; if (rx_pulses != start_pulses) begin errors++; $display("FAIL rmid_pulse_count: got %0d want %0d", rx_pulses, start_pulses); end
    test_drive(8'h96, "after_reset");
  endtask

  initial begin
    tx_data = 8'h00; tx_expect = 1'b0; tx_valid = 1'b0; pin_in = 1'b0;
    test_reset();
    test_drive(8'hA5, "drive_a5");
    test_sample();
    test_pin_noise();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
